// File: rtl/prv664_wb_pkg.sv
// Shared write-back types and default sizing for the execute-unit result arbiter.
package prv664_wb_pkg;

    localparam int unsigned WB_NUM_REQ = 4;
    localparam int unsigned WB_DWID    = 64;
    localparam int unsigned WB_TAGW    = 8;
    localparam int unsigned WB_SRC_W   = $clog2(WB_NUM_REQ);

    typedef struct packed {
        logic [WB_DWID-1:0] data;
        logic [WB_DWID-1:0] csrdata;
        logic [WB_TAGW-1:0] itag;
    } wb_res_t;

    typedef enum logic [WB_SRC_W-1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MDU = 2'd1,
        WB_SRC_LSU = 2'd2,
        WB_SRC_BRU = 2'd3
    } wb_src_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o,
    output logic                       valid_o
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned CAND_W = IDX_W + 1;

    logic [CAND_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // ptr + k never exceeds 2*NUM_REQ-2, so one subtraction wraps it
            cand = {1'b0, ptr_i} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
                grant_o[cand[IDX_W-1:0]] = 1'b1;
                idx_o                    = cand[IDX_W-1:0];
                valid_o                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the write-back port between execute units with one registered output stage.
// Define PRV664_WB_ARB_PERF_EN to add per-unit saturating grant counters (perf_grant_cnt_o).
module wb_arbiter
    import prv664_wb_pkg::*;
#(
    parameter int unsigned NUM_REQ = WB_NUM_REQ,
    parameter int unsigned DWID    = WB_DWID,
    parameter int unsigned TAGW    = WB_TAGW
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       flush_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*DWID-1:0]    req_data_i,
    input  logic [NUM_REQ*DWID-1:0]    req_csrdata_i,
    input  logic [NUM_REQ*TAGW-1:0]    req_itag_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [DWID-1:0]            wb_data_o,
    output logic [DWID-1:0]            wb_csrdata_o,
    output logic [TAGW-1:0]            wb_itag_o,
    output logic [$clog2(NUM_REQ)-1:0] wb_src_o
`ifdef PRV664_WB_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]      perf_grant_cnt_o
`endif
);

    localparam int unsigned SRC_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic [DWID-1:0] data;
        logic [DWID-1:0] csrdata;
        logic [TAGW-1:0] itag;
    } res_t;

    logic [NUM_REQ-1:0] gnt;
    logic [SRC_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               load;
    logic               take;
    res_t               sel;

    logic               valid_d, valid_q;
    res_t               res_d, res_q;
    logic [SRC_W-1:0]   src_d, src_q;
    logic [SRC_W-1:0]   ptr_d, ptr_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_any)
    );

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel.data    = req_data_i[i*DWID +: DWID];
                sel.csrdata = req_csrdata_i[i*DWID +: DWID];
                sel.itag    = req_itag_i[i*TAGW +: TAGW];
            end
        end
    end

    always_comb begin
        load        = !valid_q || wb_ready_i;
        take        = load && !flush_i && gnt_any;
        req_ready_o = (load && !flush_i) ? gnt : '0;

        valid_d = valid_q;
        res_d   = res_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = gnt_any;
            if (gnt_any) begin
                res_d = sel;
                src_d = gnt_idx;
                ptr_d = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign wb_valid_o   = valid_q;
    assign wb_data_o    = res_q.data;
    assign wb_csrdata_o = res_q.csrdata;
    assign wb_itag_o    = res_q.itag;
    assign wb_src_o     = src_q;

`ifdef PRV664_WB_ARB_PERF_EN
    logic [31:0] perf_cnt_d [NUM_REQ];
    logic [31:0] perf_cnt_q [NUM_REQ];

    // Counts survive flush; only reset clears them.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            perf_cnt_d[i] = perf_cnt_q[i];
            if (take && gnt[i] && (perf_cnt_q[i] != 32'hFFFF_FFFF)) begin
                perf_cnt_d[i] = perf_cnt_q[i] + 32'd1;
            end
            perf_grant_cnt_o[i*32 +: 32] = perf_cnt_q[i];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arst_i) begin
                perf_cnt_q[i] <= '0;
            end else begin
                perf_cnt_q[i] <= perf_cnt_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed plus random bench for wb_arbiter against a round-robin reference model.
module tb_wb_arbiter;

    localparam int N = 4;
    localparam int DW = 64;
    localparam int TW = 8;

    logic            clk_i = 1'b0;
    logic            arst_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*DW-1:0] req_data_i = '0;
    logic [N*DW-1:0] req_csrdata_i = '0;
    logic [N*TW-1:0] req_itag_i = '0;
    logic            wb_valid_o;
    logic            wb_ready_i = 1'b0;
    logic [DW-1:0]   wb_data_o;
    logic [DW-1:0]   wb_csrdata_o;
    logic [TW-1:0]   wb_itag_o;
    logic [1:0]      wb_src_o;
`ifdef PRV664_WB_ARB_PERF_EN
    logic [N*32-1:0] perf_grant_cnt_o;
`endif

    wb_arbiter #(
        .NUM_REQ (N),
        .DWID    (DW),
        .TAGW    (TW)
    ) dut (
        .clk_i         (clk_i),
        .arst_i        (arst_i),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_data_i    (req_data_i),
        .req_csrdata_i (req_csrdata_i),
        .req_itag_i    (req_itag_i),
        .wb_valid_o    (wb_valid_o),
        .wb_ready_i    (wb_ready_i),
        .wb_data_o     (wb_data_o),
        .wb_csrdata_o  (wb_csrdata_o),
        .wb_itag_o     (wb_itag_o),
        .wb_src_o      (wb_src_o)
`ifdef PRV664_WB_ARB_PERF_EN
        ,
        .perf_grant_cnt_o (perf_grant_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;

    // Per-unit result sources
    logic [DW-1:0] d [N];
    logic [DW-1:0] c [N];
    logic [TW-1:0] t [N];

    // Reference model state
    int            m_ptr = 0;
    bit            m_valid = 0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_csr = '0;
    logic [TW-1:0] m_itag = '0;
    int            m_src = 0;
    int            m_last_grant = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic randomize_sources();
        for (int i = 0; i < N; i++) begin
            d[i] = {$urandom, $urandom};
            c[i] = {$urandom, $urandom};
            t[i] = 8'($urandom);
        end
    endtask

    // One clock: drive, check ready mid-cycle, advance model at the edge, check outputs.
    task automatic step(input logic [N-1:0] rv, input logic wbr, input logic fl,
                        input logic rs);
        int g;
        bit ld;
        logic [N-1:0] exp_rdy;
        req_valid_i = rv;
        wb_ready_i  = wbr;
        flush_i     = fl;
        arst_i      = rs;
        for (int i = 0; i < N; i++) begin
            req_data_i[i*DW +: DW]    = d[i];
            req_csrdata_i[i*DW +: DW] = c[i];
            req_itag_i[i*TW +: TW]    = t[i];
        end
        #4;
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        ld = !m_valid || wbr;
        exp_rdy = (ld && !fl && g >= 0) ? N'(1 << g) : '0;
        if (!rs) chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        @(posedge clk_i);
        m_last_grant = -1;
        if (rs) begin
            m_valid = 0; m_data = '0; m_csr = '0; m_itag = '0; m_src = 0; m_ptr = 0;
        end else if (fl) begin
            m_valid = 0;
        end else if (ld) begin
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_data = d[g]; m_csr = c[g]; m_itag = t[g]; m_src = g;
                m_ptr = (g + 1) % N;
                m_last_grant = g;
            end
        end
        #1;
        chk("wb_valid", 64'(wb_valid_o), 64'(m_valid));
        if (m_valid || rs) begin
            chk("wb_data", wb_data_o, m_data);
            chk("wb_csrdata", wb_csrdata_o, m_csr);
            chk("wb_itag", 64'(wb_itag_o), 64'(m_itag));
            chk("wb_src", 64'(wb_src_o), 64'(m_src));
        end
    endtask

    initial begin
        logic [DW-1:0] held;
        randomize_sources();

        // Reset state
        step('0, 1'b0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0, 1'b1);
        chk("reset_valid", 64'(wb_valid_o), 64'd0);
        chk("reset_data", wb_data_o, 64'd0);

        // Unit 2 alone
        d[2] = 64'h1234; t[2] = 8'h05;
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        chk("u2_data", wb_data_o, 64'h1234);
        chk("u2_itag", 64'(wb_itag_o), 64'h05);
        chk("u2_src", 64'(wb_src_o), 64'd2);

        // ptr=3 now; grant unit 3 to bring ptr to 0
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        // All requesting: grants 0,1,2,3,0 with no bubbles
        for (int i = 0; i < 5; i++) begin
            randomize_sources();
            step(4'b1111, 1'b1, 1'b0, 1'b0);
            chk("rr_src_seq", 64'(wb_src_o), 64'(i % N));
        end

        // Back-pressure for 3 cycles then release
        held = wb_data_o;
        for (int i = 0; i < 3; i++) begin
            randomize_sources();
            step(4'b1111, 1'b0, 1'b0, 1'b0);
            chk("stall_hold", wb_data_o, held);
        end
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("release_src", 64'(wb_src_o), 64'd1);

        // Wrap: bring ptr to 3, then 1001 grants 3 then 0
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        step(4'b1001, 1'b1, 1'b0, 1'b0);
        chk("wrap_src3", 64'(wb_src_o), 64'd3);
        step(4'b1001, 1'b1, 1'b0, 1'b0);
        chk("wrap_src0", 64'(wb_src_o), 64'd0);

        // Flush while valid; ptr (now 1) must hold
        step(4'b0010, 1'b0, 1'b1, 1'b0);
        chk("flush_valid", 64'(wb_valid_o), 64'd0);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("post_flush_src", 64'(wb_src_o), 64'd1);

        // Reset mid-transfer
        step(4'b1111, 1'b0, 1'b0, 1'b1);
        chk("midreset_valid", 64'(wb_valid_o), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            randomize_sources();
            step(N'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 49) == 0));
        end

`ifdef PRV664_WB_ARB_PERF_EN
        step('0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b0010, 1'b1, 1'b0, 1'b0);
        chk("perf_cnt1", 64'(perf_grant_cnt_o[63:32]), 64'd5);
        step(4'b0010, 1'b1, 1'b1, 1'b0);
        chk("perf_flush_keep", 64'(perf_grant_cnt_o[63:32]), 64'd5);
        force dut.perf_cnt_q[1] = 32'hFFFF_FFFF;
        #1;
        release dut.perf_cnt_q[1];
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        chk("perf_saturate", 64'(perf_grant_cnt_o[63:32]), 64'hFFFF_FFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
